// File: rtl/dram_cpu_bridge.sv
// Register-mapped CPU requester for one DRAM arbiter slave port: stages a
// 2-beat x 144-bit burst, issues it, and captures read-return beats.
module dram_cpu_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_req,
    input  logic         cpu_rnw,
    input  logic [4:0]   cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic         cpu_ack,
    output logic [31:0]  cpu_rdata,
    output logic [31:0]  dram_cmd_addr,
    output logic         dram_cmd_rnw,
    output logic         dram_cmd_valid,
    output logic [143:0] dram_wr_data,
    output logic [17:0]  dram_wr_be,
    input  logic [143:0] dram_rd_data,
    input  logic         dram_rd_valid,
    input  logic         dram_ack
);
    // state  | meaning
    // IDLE   | waiting for an accepted go
    // CMD    | command presented, waiting for arbiter grant (beat0 on write data)
    // WDATA1 | write beat1 presented for one cycle
    // RWAIT  | collecting two read beats, bounded by TIMEOUT_CYCLES
    typedef enum logic [1:0] {IDLE, CMD, WDATA1, RWAIT} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t state, state_nxt;

    logic [31:0]  addr_q;
    logic [143:0] wbuf0, wbuf1, rbuf0, rbuf1;
    logic [17:0]  be0, be1;
    logic         rnw_q, done, timeout, err;
    logic         beat_cnt;
    logic [CW-1:0] cyc_cnt;

    logic        busy, wr_acc, go_ctrl, go_ok, go_bad;
    logic [1:0]  go;
    logic        wr_beat1, rd_load0, rd_load1, fin_done, fin_to;
    logic [31:0] rd_mux;

    function automatic logic [31:0] get_word(input logic [143:0] b, input logic [2:0] w);
        if (w == 3'd4) return {16'h0, b[143:128]};
        return b[{w[1:0], 5'b0} +: 32];
    endfunction

    function automatic logic [143:0] put_word(input logic [143:0] b, input logic [2:0] w,
                                              input logic [31:0] d);
        logic [143:0] r;
        r = b;
        if (w == 3'd4) r[143:128] = d[15:0];
        else           r[{w[1:0], 5'b0} +: 32] = d;
        return r;
    endfunction

    assign busy    = (state != IDLE);
    assign wr_acc  = cpu_req && !cpu_rnw;
    assign go      = cpu_wdata[1:0];
    assign go_ctrl = wr_acc && (cpu_addr == 5'd0) && (go != 2'b00);
    assign go_ok   = go_ctrl && !busy && (go != 2'b11);
    assign go_bad  = go_ctrl && !go_ok;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        dram_cmd_valid = 1'b0;
        wr_beat1       = 1'b0;
        rd_load0       = 1'b0;
        rd_load1       = 1'b0;
        fin_done       = 1'b0;
        fin_to         = 1'b0;
        case (state)
            IDLE: begin
                if (go_ok) state_nxt = CMD;
            end
            CMD: begin
                dram_cmd_valid = 1'b1;
                if (dram_ack) state_nxt = rnw_q ? RWAIT : WDATA1;
            end
            WDATA1: begin
                wr_beat1  = 1'b1;
                fin_done  = 1'b1;
                state_nxt = IDLE;
            end
            RWAIT: begin
                if (dram_rd_valid) begin
                    if (!beat_cnt) begin
                        rd_load0 = 1'b1;
                    end else begin
                        rd_load1  = 1'b1;
                        fin_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                // A second beat landing on the last counted cycle still completes
                if (!rd_load1 && cyc_cnt == CNT_LAST) begin
                    fin_to    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'h0;
        if (cpu_addr == 5'd0)                          rd_mux = {28'h0, err, timeout, done, busy};
        else if (cpu_addr == 5'd1)                     rd_mux = addr_q;
        else if (cpu_addr >= 5'd2  && cpu_addr <= 5'd6)  rd_mux = get_word(wbuf0, 3'(cpu_addr - 5'd2));
        else if (cpu_addr >= 5'd7  && cpu_addr <= 5'd11) rd_mux = get_word(wbuf1, 3'(cpu_addr - 5'd7));
        else if (cpu_addr == 5'd12)                    rd_mux = {14'h0, be0};
        else if (cpu_addr == 5'd13)                    rd_mux = {14'h0, be1};
        else if (cpu_addr >= 5'd14 && cpu_addr <= 5'd18) rd_mux = get_word(rbuf0, 3'(cpu_addr - 5'd14));
        else if (cpu_addr >= 5'd19 && cpu_addr <= 5'd23) rd_mux = get_word(rbuf1, 3'(cpu_addr - 5'd19));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= 32'h0;
            addr_q    <= 32'h0;
            wbuf0     <= '0;
            wbuf1     <= '0;
            be0       <= '0;
            be1       <= '0;
            rbuf0     <= '0;
            rbuf1     <= '0;
            rnw_q     <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            err       <= 1'b0;
            beat_cnt  <= 1'b0;
            cyc_cnt   <= '0;
        end else begin
            cpu_ack   <= cpu_req;
            cpu_rdata <= (cpu_req && cpu_rnw) ? rd_mux : 32'h0;

            if (wr_acc && !busy) begin
                if (cpu_addr == 5'd1)                          addr_q <= cpu_wdata;
                else if (cpu_addr >= 5'd2 && cpu_addr <= 5'd6)  wbuf0 <= put_word(wbuf0, 3'(cpu_addr - 5'd2), cpu_wdata);
                else if (cpu_addr >= 5'd7 && cpu_addr <= 5'd11) wbuf1 <= put_word(wbuf1, 3'(cpu_addr - 5'd7), cpu_wdata);
                else if (cpu_addr == 5'd12)                    be0 <= cpu_wdata[17:0];
                else if (cpu_addr == 5'd13)                    be1 <= cpu_wdata[17:0];
            end

            if (rd_load0) rbuf0 <= dram_rd_data;
            if (rd_load1) rbuf1 <= dram_rd_data;

            if (go_ok) rnw_q <= go[0];

            if (go_ok) begin
                done    <= 1'b0;
                timeout <= 1'b0;
                err     <= 1'b0;
            end else begin
                if (go_bad)   err     <= 1'b1;
                if (fin_done) done    <= 1'b1;
                if (fin_to)   timeout <= 1'b1;
            end

            // Counters restart whenever RWAIT is not active, so each entry begins at 0
            if (state != RWAIT) begin
                beat_cnt <= 1'b0;
                cyc_cnt  <= '0;
            end else begin
                if (rd_load0) beat_cnt <= 1'b1;
                cyc_cnt <= cyc_cnt + CW'(1);
            end
        end
    end

    assign dram_cmd_addr = addr_q;
    assign dram_cmd_rnw  = rnw_q;
    assign dram_wr_data  = wr_beat1 ? wbuf1 : wbuf0;
    assign dram_wr_be    = wr_beat1 ? be1 : be0;

endmodule

// File: tb/tb_dram_cpu_bridge.sv
// Self-checking bench for dram_cpu_bridge: register-file/status model plus
// directed write, read, timeout, busy-protection and reset scenarios.
module tb_dram_cpu_bridge;
    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_rnw;
    logic [4:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_ack;
    logic [31:0]  cpu_rdata;
    logic [31:0]  dram_cmd_addr;
    logic         dram_cmd_rnw, dram_cmd_valid;
    logic [143:0] dram_wr_data;
    logic [17:0]  dram_wr_be;
    logic [143:0] dram_rd_data;
    logic         dram_rd_valid, dram_ack;

    always #5 clk = ~clk;

    dram_cpu_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dram_cmd_addr(dram_cmd_addr), .dram_cmd_rnw(dram_cmd_rnw), .dram_cmd_valid(dram_cmd_valid),
        .dram_wr_data(dram_wr_data), .dram_wr_be(dram_wr_be),
        .dram_rd_data(dram_rd_data), .dram_rd_valid(dram_rd_valid), .dram_ack(dram_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the software-visible state
    logic [31:0] m_addr;
    logic [31:0] m_wb[2][5];
    logic [17:0] m_be[2];
    logic [31:0] m_rb[2][5];
    bit          m_busy, m_done, m_to, m_err;

    logic [31:0] exp_q[$];
    int          tag_q[$];

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_addr = 0; m_busy = 0; m_done = 0; m_to = 0; m_err = 0;
        for (int b = 0; b < 2; b++) begin
            m_be[b] = 0;
            for (int w = 0; w < 5; w++) begin
                m_wb[b][w] = 0;
                m_rb[b][w] = 0;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        if (a == 0)            return {28'h0, m_err, m_to, m_done, m_busy};
        if (a == 1)            return m_addr;
        if (a >= 2 && a <= 6)  return m_wb[0][a-2];
        if (a >= 7 && a <= 11) return m_wb[1][a-7];
        if (a == 12)           return {14'h0, m_be[0]};
        if (a == 13)           return {14'h0, m_be[1]};
        if (a >= 14 && a <= 18) return m_rb[0][a-14];
        if (a >= 19 && a <= 23) return m_rb[1][a-19];
        return 32'h0;
    endfunction

    function automatic logic [143:0] beat(input int b);
        return {m_wb[b][4][15:0], m_wb[b][3], m_wb[b][2], m_wb[b][1], m_wb[b][0]};
    endfunction

    task automatic store_rbuf(input int b, input logic [143:0] d);
        for (int w = 0; w < 4; w++) m_rb[b][w] = d[32*w +: 32];
        m_rb[b][4] = {16'h0, d[143:128]};
    endtask

    task automatic reg_wr(input int a, input logic [31:0] d);
        cpu_req = 1; cpu_rnw = 0; cpu_addr = 5'(a); cpu_wdata = d;
        if (a == 0) begin
            if (d[1:0] != 2'b00) begin
                if (d[1:0] == 2'b11 || m_busy) m_err = 1;
                else begin
                    m_err = 0; m_done = 0; m_to = 0; m_busy = 1;
                end
            end
        end else if (!m_busy) begin
            if (a == 1) m_addr = d;
            else if (a >= 2 && a <= 11) begin
                int b, w;
                b = (a <= 6) ? 0 : 1;
                w = (a <= 6) ? a - 2 : a - 7;
                m_wb[b][w] = (w == 4) ? {16'h0, d[15:0]} : d;
            end
            else if (a == 12) m_be[0] = d[17:0];
            else if (a == 13) m_be[1] = d[17:0];
        end
        tick();
        cpu_req = 0;
    endtask

    task automatic reg_rd_exp(input int a, input logic [31:0] e);
        cpu_req = 1; cpu_rnw = 1; cpu_addr = 5'(a); cpu_wdata = 0;
        exp_q.push_back(e);
        tag_q.push_back(a);
        tick();
        cpu_req = 0;
    endtask

    task automatic reg_rd(input int a);
        reg_rd_exp(a, model_read(a));
    endtask

    // Arbiter side of a write burst; entered while the command is pending
    task automatic service_write(input int grant_delay);
        for (int i = 0; i < grant_delay; i++) begin
            chk("wr_cmd_valid_hold", dram_cmd_valid, 1'b1);
            chk("wr_cmd_rnw", dram_cmd_rnw, 1'b0);
            chk("wr_cmd_addr", dram_cmd_addr, m_addr);
            tick();
        end
        dram_ack = 1;
        chk("wr_ack_valid", dram_cmd_valid, 1'b1);
        chk("wr_beat0_data", dram_wr_data, beat(0));
        chk("wr_beat0_be", dram_wr_be, m_be[0]);
        tick();
        dram_ack = 0;
        chk("wr_beat1_valid_low", dram_cmd_valid, 1'b0);
        chk("wr_beat1_data", dram_wr_data, beat(1));
        chk("wr_beat1_be", dram_wr_be, m_be[1]);
        tick();
        m_busy = 0; m_done = 1;
        chk("wr_after_valid_low", dram_cmd_valid, 1'b0);
        chk("wr_after_beat0", dram_wr_data, beat(0));
    endtask

    task automatic service_read(input logic [143:0] b0, input logic [143:0] b1, input int gap);
        chk("rd_cmd_valid", dram_cmd_valid, 1'b1);
        chk("rd_cmd_rnw", dram_cmd_rnw, 1'b1);
        chk("rd_cmd_addr", dram_cmd_addr, m_addr);
        dram_ack = 1;
        tick();
        dram_ack = 0;
        chk("rd_valid_dropped", dram_cmd_valid, 1'b0);
        dram_rd_valid = 1; dram_rd_data = b0; store_rbuf(0, b0);
        tick();
        dram_rd_valid = 0; dram_rd_data = 0;
        repeat (gap) tick();
        dram_rd_valid = 1; dram_rd_data = b1; store_rbuf(1, b1);
        tick();
        dram_rd_valid = 0; dram_rd_data = 0;
        m_busy = 0; m_done = 1;
    endtask

    // cpu_ack must follow cpu_req by one cycle; read data matches the queued expectation
    always begin
        logic req_s, rnw_s;
        @(posedge clk);
        req_s = cpu_req;
        rnw_s = cpu_rnw;
        #1;
        chk("cpu_ack", cpu_ack, req_s);
        if (req_s && rnw_s) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rdata_unexpected: got %h expected no read", cpu_rdata);
            end else begin
                logic [31:0] e;
                int t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk($sformatf("rdata_addr%0d", t), cpu_rdata, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [143:0] t0;
        rst = 1; cpu_req = 0; cpu_rnw = 0; cpu_addr = 0; cpu_wdata = 0;
        dram_rd_data = 0; dram_rd_valid = 0; dram_ack = 0;
        model_reset();
        repeat (3) tick();
        chk("rst_cmd_valid", dram_cmd_valid, 1'b0);
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        rst = 0;
        tick();

        for (int a = 0; a < 24; a++) reg_rd_exp(a, 32'h0);

        // Write burst
        reg_wr(1, 32'h100);
        for (int w = 0; w < 5; w++) begin
            reg_wr(2 + w, 32'h11111111);
            reg_wr(7 + w, 32'h22222222);
        end
        reg_wr(12, 32'h3FFFF);
        reg_wr(13, 32'h3FFFF);
        reg_rd_exp(6, 32'h00001111);
        reg_rd(12);
        reg_wr(0, 32'h2);
        chk("wr_cmd_addr_lit", dram_cmd_addr, 32'h100);
        chk("wr_beat0_lit", dram_wr_data, {16'h1111, {4{32'h11111111}}});
        service_write(3);
        reg_rd_exp(0, 32'h2);

        // Read burst
        reg_wr(1, 32'h200);
        reg_wr(0, 32'h1);
        service_read({144{1'b1}} / 3 * 2, {144{1'b1}} / 3, 2);
        reg_rd_exp(14, 32'hAAAAAAAA);
        reg_rd_exp(18, 32'h0000AAAA);
        reg_rd_exp(19, 32'h55555555);
        reg_rd_exp(23, 32'h00005555);
        for (int a = 15; a <= 22; a++) reg_rd(a);
        reg_rd_exp(0, 32'h2);

        // Timeout: one beat then silence; boundary at the 8th RWAIT cycle
        t0 = {16'hBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 32'h4B5A6978};
        reg_wr(0, 32'h1);
        chk("to_cmd_valid", dram_cmd_valid, 1'b1);
        dram_ack = 1;
        tick();
        dram_ack = 0;
        dram_rd_valid = 1; dram_rd_data = t0; store_rbuf(0, t0);
        tick();
        dram_rd_valid = 0; dram_rd_data = 0;
        repeat (5) tick();
        reg_rd_exp(0, 32'h1);
        reg_rd_exp(0, 32'h1);
        m_busy = 0; m_to = 1;
        reg_rd_exp(0, 32'h4);
        dram_rd_valid = 1; dram_rd_data = {144{1'b1}};
        tick();
        dram_rd_valid = 0; dram_rd_data = 0;
        reg_rd_exp(19, 32'h55555555);
        reg_rd_exp(23, 32'h00005555);
        reg_rd_exp(14, 32'h4B5A6978);
        reg_rd(18);
        reg_rd_exp(0, 32'h4);

        // Busy protection
        reg_wr(1, 32'h300);
        reg_wr(0, 32'h2);
        reg_wr(4, 32'hDEADBEEF);
        reg_wr(0, 32'h1);
        reg_rd_exp(0, 32'h9);
        reg_rd_exp(4, 32'h11111111);
        service_write(1);
        reg_rd_exp(0, 32'hA);
        reg_wr(0, 32'h1);
        reg_rd_exp(0, 32'h1);
        service_read({9{16'h3C5A}}, {9{16'h0FF0}}, 0);
        reg_rd(14);
        reg_rd(23);
        reg_rd_exp(0, 32'h2);

        // go = 11 while idle, unmapped and read-only addresses
        reg_wr(0, 32'h3);
        for (int i = 0; i < 3; i++) begin
            chk("go11_no_cmd", dram_cmd_valid, 1'b0);
            tick();
        end
        reg_rd_exp(0, 32'hA);
        reg_wr(24, 32'h1234);
        reg_rd_exp(24, 32'h0);
        reg_rd_exp(31, 32'h0);
        reg_wr(14, 32'hFFFFFFFF);
        reg_rd(14);

        // Reset during RWAIT
        reg_wr(0, 32'h1);
        dram_ack = 1;
        tick();
        dram_ack = 0;
        dram_rd_valid = 1; dram_rd_data = {144{1'b1}};
        tick();
        dram_rd_valid = 0; dram_rd_data = 0;
        rst = 1;
        tick();
        chk("rstmid_cmd_valid", dram_cmd_valid, 1'b0);
        chk("rstmid_cmd_addr", dram_cmd_addr, 32'h0);
        chk("rstmid_cmd_rnw", dram_cmd_rnw, 1'b0);
        chk("rstmid_wr_data", dram_wr_data, 144'h0);
        chk("rstmid_wr_be", dram_wr_be, 18'h0);
        chk("rstmid_cpu_ack", cpu_ack, 1'b0);
        chk("rstmid_cpu_rdata", cpu_rdata, 32'h0);
        rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_no_cmd", dram_cmd_valid, 1'b0);
            tick();
        end
        reg_rd_exp(0, 32'h0);
        reg_rd_exp(1, 32'h0);
        reg_rd_exp(14, 32'h0);
        reg_rd(19);

        repeat (2) tick();
        chk("exp_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dram_cpu_bridge.md
Name: dram_cpu_bridge

Overview:
- Register-mapped CPU-side requester that drives one slave port of the DRAM arbiter, for example the sniffer's slave1 port.
- Software stages an address, two 144-bit write beats with byte enables, and a command.
- The block issues a single DRAM read or write burst of 2 beats x 144 bits.
- It captures the two read-return beats into a readable buffer and reports busy, done and timeout status.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles spent in RWAIT before a read is abandoned. Must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cpu_req  in  1  single-cycle register access strobe
- cpu_rnw  in  1  1 = register read, 0 = register write
- cpu_addr  in  5  register word address
- cpu_wdata  in  32  register write data
- cpu_ack  out  1  one-cycle acknowledge, asserted the cycle after cpu_req
- cpu_rdata  out  32  register read data, valid while cpu_ack = 1
- dram_cmd_addr  out  32  DRAM burst address
- dram_cmd_rnw  out  1  1 = read burst, 0 = write burst
- dram_cmd_valid  out  1  command request toward the arbiter
- dram_wr_data  out  144  write beat data
- dram_wr_be  out  18  write beat byte enables
- dram_rd_data  in  144  read beat data (registered by the arbiter)
- dram_rd_valid  in  1  read beat strobe routed to this port
- dram_ack  in  1  arbiter grant; the command is accepted on any cycle with dram_cmd_valid && dram_ack

Behaviour:
Reset:
- State is IDLE; all registers and buffers are 0.
- dram_cmd_valid = 0, cpu_ack = 0, cpu_rdata = 0, done = 0, timeout = 0.
- Reset mid-burst abandons the operation immediately, with no further dram_cmd_valid.

Register map (word addresses):
- 0 CTRL/STATUS.
  - Write: bit0 = go_read, bit1 = go_write.
  - Read: bit0 busy, bit1 done, bit2 timeout, bit3 err; all other bits 0.
- 1 ADDR[31:0].
- 2-6 WBUF beat0 words 0-4.
- 7-11 WBUF beat1 words 0-4.
- 12 BE0[17:0].
- 13 BE1[17:0].
- 14-18 RBUF beat0.
- 19-23 RBUF beat1.
- Word w of a beat maps to beat bits [32w+31:32w]. Word 4 maps to bits [143:128] in its low 16 bits; its upper 16 bits read 0 and are ignored on write.
- Unmapped addresses read 0; writes to them are ignored.

CPU access rules:
- cpu_ack pulses exactly 1 cycle after every cpu_req, whether the access is a read or a write and whether the block is busy.
- Writes to ADDR, WBUF and BE while busy are ignored.
- RBUF is read-only; writes to it are ignored.
- A CTRL write with go = 2'b11, or with any go bit set while busy, is ignored and sets err. err is cleared by the next accepted go.
- An accepted go clears done, timeout and err.

FSM:
- IDLE: on an accepted go, latch rnw (go_read = 1), go to CMD next cycle.
- CMD:
  - dram_cmd_valid = 1; dram_cmd_addr = ADDR; dram_cmd_rnw = latched rnw.
  - dram_wr_data/dram_wr_be = beat0.
  - On dram_ack: write goes to WDATA1, read goes to RWAIT.
  - If dram_ack is never asserted, the block stays in CMD indefinitely.
- WDATA1:
  - dram_cmd_valid = 0; dram_wr_data/dram_wr_be = beat1 for exactly this one cycle.
  - Next state IDLE with done = 1.
- RWAIT:
  - First dram_rd_valid loads RBUF beat0; second loads RBUF beat1, then IDLE with done = 1.
  - The beat counter is 1 bit and is reset on entry to RWAIT.
  - A cycle counter counts up from 0 on entry. When it reaches TIMEOUT_CYCLES-1 with fewer than 2 beats received, go to IDLE with timeout = 1 and done = 0. RBUF keeps any partial data.
- dram_rd_valid outside RWAIT is dropped, so late beats after a timeout cannot corrupt RBUF.
- Outside WDATA1, dram_wr_data/dram_wr_be present beat0.
- busy = (state != IDLE).
- Write latency: accepted go to done = 1 is 1 (IDLE->CMD) + grant wait + 1 cycles.

Test Plan:
- Reset, then read every register 0-23 -> all read 0x00000000; cpu_ack is high exactly 1 cycle after each cpu_req.
- Write burst:
  - Setup: ADDR = 0x100, beat0 words = 0x11111111..., beat1 words = 0x22222222..., BE0 = BE1 = 0x3FFFF, go_write.
  - Arbiter model grants after 3 cycles.
  - Required: dram_cmd_valid is held until ack, with dram_cmd_rnw = 0 and addr 0x100. On the ack cycle dram_wr_data = beat0; the next cycle = beat1. Status then reads done = 1, busy = 0.
- Read burst:
  - Setup: go_read at ADDR = 0x200; return beats 0xAAA..A and 0x555..5 separated by 2 idle cycles.
  - Required: RBUF words 14-18 = 0xAAAAAAAA (word 18 = 0x0000AAAA), words 19-23 = 0x55555555 (word 23 = 0x00005555); done = 1.
- Timeout (TIMEOUT_CYCLES = 8): go_read, grant, return only one beat -> timeout = 1 and done = 0 after 8 RWAIT cycles. A late second beat leaves RBUF beat1 unchanged.
- Busy protection: during CMD, write WBUF word 2 and CTRL go_read -> both are ignored and err = 1. The burst completes with the original data. The next go clears err.
- go = 2'b11 while IDLE -> no dram_cmd_valid, err = 1, busy stays 0. Asserting rst during RWAIT -> next cycle state is IDLE, all outputs are 0, and no command is issued.
